// File: rtl/sandbox_host_bridge_pkg.sv
// Shared types and constants for the sandbox host bridge.
// Frame geometry, FSM state encodings and error bit positions.
package sandbox_host_bridge_pkg;

  localparam int FRAME_BYTES = 5;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  localparam int ERR_RX_OVERRUN   = 0;
  localparam int ERR_TX_COLLISION = 1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_COLLECT,
    RX_HOLD
  } rxState_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } txState_t;

endpackage

// File: rtl/sandbox_host_bridge_if.sv
// UART-side byte stream between the bridge and the rx/tx byte modules.
// master = UART side, slave = bridge side.
interface sandbox_host_bridge_if;

  logic       rxValid;
  logic [7:0] rxByte;
  logic [7:0] txByte;
  logic       txValid;
  logic       txReady;

  modport master (
    output rxValid,
    output rxByte,
    output txReady,
    input  txByte,
    input  txValid
  );

  modport slave (
    input  rxValid,
    input  rxByte,
    input  txReady,
    output txByte,
    output txValid
  );

endinterface

// File: rtl/sandbox_tx_serializer.sv
// Response serializer: registered edge detect on transmitData,
// 40-bit capture of {status, outputData}, MSB-first valid/ready output.
module sandbox_tx_serializer
  import sandbox_host_bridge_pkg::*;
(
  input  logic        masterClock,
  input  logic        reset,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  input  logic        txReady,
  output logic        txValid,
  output logic [7:0]  txByte,
  output logic        collision
);

  txState_t    txState;
  txState_t    txNext;
  logic        tdReg;
  logic        tdPrev;
  logic [39:0] shiftReg;
  logic [2:0]  txIndex;
  logic        rise;
  logic        capture;
  logic        advance;

  assign rise    = tdReg & ~tdPrev;
  assign txValid = (txState == TX_SEND);
  assign txByte  = shiftReg[39:32];

  // Next-state and strobes; a new edge while sending is only flagged.
  always_comb begin
    txNext    = txState;
    capture   = 1'b0;
    advance   = 1'b0;
    collision = 1'b0;
    unique case (txState)
      TX_IDLE: begin
        if (rise) begin
          capture = 1'b1;
          txNext  = TX_SEND;
        end
      end
      TX_SEND: begin
        collision = rise;
        if (txReady) begin
          advance = 1'b1;
          if (txIndex == LAST_IDX) begin
            txNext = TX_IDLE;
          end
        end
      end
      default: txNext = TX_IDLE;
    endcase
  end

  // State, edge-detect pipeline and the byte shift register.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      txState  <= TX_IDLE;
      tdReg    <= 1'b0;
      tdPrev   <= 1'b0;
      shiftReg <= '0;
      txIndex  <= '0;
    end else begin
      txState <= txNext;
      tdReg   <= transmitData;
      tdPrev  <= tdReg;
      if (capture) begin
        shiftReg <= {status, outputData};
        txIndex  <= '0;
      end else if (advance) begin
        shiftReg <= {shiftReg[31:0], 8'h00};
        txIndex  <= (txIndex == LAST_IDX) ? 3'd0 : txIndex + 3'd1;
      end
    end
  end

endmodule

// File: rtl/sandbox_host_bridge.sv
// Host framing bridge: assembles 5-byte request frames from the UART,
// holds them for the process, and frames responses back out.
module sandbox_host_bridge
  import sandbox_host_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 masterClock,
  input  logic                 reset,
  sandbox_host_bridge_if.slave uart,
  output logic                 dataReceived,
  output logic [7:0]           control,
  output logic [31:0]          inputData,
  input  logic                 clearDR,
  input  logic                 transmitData,
  input  logic [7:0]           status,
  input  logic [31:0]          outputData,
  output logic                 frameTimeout,
  output logic [1:0]           error
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  rxState_t      rxState;
  rxState_t      rxNext;
  logic [2:0]    byteCount;
  logic [TW-1:0] timer;
  logic          acceptByte;
  logic          frameDone;
  logic          timeoutHit;
  logic          overrun;
  logic          txCollision;

  // Rx next-state; a byte arriving on the timeout cycle keeps the frame.
  always_comb begin
    rxNext     = rxState;
    acceptByte = 1'b0;
    frameDone  = 1'b0;
    timeoutHit = 1'b0;
    overrun    = 1'b0;
    unique case (rxState)
      RX_IDLE: begin
        if (uart.rxValid) begin
          acceptByte = 1'b1;
          rxNext     = RX_COLLECT;
        end
      end
      RX_COLLECT: begin
        if (uart.rxValid) begin
          acceptByte = 1'b1;
          if (byteCount == LAST_IDX) begin
            frameDone = 1'b1;
            rxNext    = RX_HOLD;
          end
        end else if (timer == T_LAST) begin
          timeoutHit = 1'b1;
          rxNext     = RX_IDLE;
        end
      end
      RX_HOLD: begin
        overrun = uart.rxValid;
        if (clearDR) begin
          rxNext = RX_IDLE;
        end
      end
      default: rxNext = RX_IDLE;
    endcase
  end

  // Rx state, frame assembly, inactivity timer and sticky errors.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      rxState      <= RX_IDLE;
      byteCount    <= '0;
      timer        <= '0;
      control      <= '0;
      inputData    <= '0;
      dataReceived <= 1'b0;
      frameTimeout <= 1'b0;
      error        <= '0;
    end else begin
      rxState      <= rxNext;
      frameTimeout <= timeoutHit;
      if (acceptByte || rxState != RX_COLLECT) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if (rxState == RX_IDLE && acceptByte) begin
        control   <= uart.rxByte;
        byteCount <= 3'd1;
      end
      if (rxState == RX_COLLECT && acceptByte) begin
        inputData <= {inputData[23:0], uart.rxByte};
        byteCount <= frameDone ? 3'd0 : byteCount + 3'd1;
      end
      if (timeoutHit) begin
        byteCount <= '0;
      end
      if (frameDone) begin
        dataReceived <= 1'b1;
      end else if (rxState == RX_HOLD && clearDR) begin
        dataReceived <= 1'b0;
      end
      if (overrun) begin
        error[ERR_RX_OVERRUN] <= 1'b1;
      end
      if (txCollision) begin
        error[ERR_TX_COLLISION] <= 1'b1;
      end
    end
  end

  sandbox_tx_serializer txSer (
    .masterClock  (masterClock),
    .reset        (reset),
    .transmitData (transmitData),
    .status       (status),
    .outputData   (outputData),
    .txReady      (uart.txReady),
    .txValid      (uart.txValid),
    .txByte       (uart.txByte),
    .collision    (txCollision)
  );

endmodule

// File: doc/sandbox_host_bridge.md
# sandbox_host_bridge

Host-side framing bridge between the UART byte stream and the sandbox process's word-level handshake. It assembles 5-byte request frames (control, then data MSB-first) into `control`/`inputData`, raises `dataReceived`, and holds them until the process returns `clearDR`. On each rising edge of `transmitData` it serializes `status` plus `outputData` into a 5-byte response frame. It sits between the UART rx/tx byte modules and the sandbox process.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 50000: masterClock cycles without a byte before a partial rx frame is discarded; must be ≥ 2.

Ports:
- `masterClock` in 1: single operating clock.
- `reset` in 1: synchronous, active-high reset.
- `rxValid` in 1: one-cycle pulse, `rxByte` valid.
- `rxByte` in 8: received byte.
- `txByte` out 8: byte to UART transmitter.
- `txValid` out 1: `txByte` valid; transfer on `txValid && txReady`.
- `txReady` in 1: UART transmitter can accept.
- `dataReceived` out 1: request frame complete, outputs valid.
- `control` out 8: frame byte 0.
- `inputData` out 32: frame bytes 1–4, byte 1 = bits 31:24.
- `clearDR` in 1: process has consumed the request.
- `transmitData` in 1: process response ready (level; edge-detected).
- `status` in 8: response byte 0.
- `outputData` in 32: response bytes 1–4, MSB first.
- `frameTimeout` out 1: one-cycle pulse, partial frame discarded.
- `error` out 2: sticky; bit0 rx overrun, bit1 tx collision.

## Operation
- Reset values: `dataReceived`=0, `control`=0, `inputData`=0, `txValid`=0, `txByte`=0, `frameTimeout`=0, `error`=0; rx FSM RX_IDLE, byte count 0; tx FSM TX_IDLE; registered `transmitData` = 0.
- Rx FSM: RX_IDLE → RX_COLLECT on first `rxValid` (byte → `control`, count=1). RX_COLLECT shifts bytes into `inputData` (shift left 8, insert at [7:0]); on 5th byte → RX_HOLD, `dataReceived`=1. RX_HOLD → RX_IDLE when `clearDR`=1 sampled; `dataReceived`=0 next cycle.
- `control`/`inputData` stable for the whole of RX_HOLD; `inputData` only updated by shifting in RX_COLLECT.
- `rxValid` in RX_HOLD (including the cycle `clearDR` is sampled): byte dropped, `error[0]`=1.
- Timeout: counter cleared on every accepted byte, counts in RX_COLLECT; at `TIMEOUT_CYCLES`-1 → RX_IDLE, count=0, `frameTimeout` pulse. `rxValid` on the timeout cycle wins: byte accepted, counter cleared, no timeout.
- Tx FSM: TX_IDLE; rising edge (`transmitData`=1, previous 0) captures `{status, outputData}` into a 40-bit shift register, index=0, → TX_SEND with `txValid`=1, `txByte`=`status`. Each transfer advances the index; after 5th transfer `txValid`=0, → TX_IDLE.
- `txByte` stable while `txValid && !txReady`.
- Rising edge during TX_SEND: ignored, `error[1]`=1. `transmitData` held high produces exactly one frame.
- Rx and tx run independently; both may be active in the same cycle.
- Reset mid-frame: both FSMs abort immediately, partial bytes lost, outputs to reset values.

## Timing
- `dataReceived` rises the cycle after the 5th `rxValid`.
- `clearDR` high in cycle N → `dataReceived` low in N+1. The next frame's first byte is accepted from N+1.
- `txValid` rises the cycle after the `transmitData` rising edge is seen (2 cycles after `transmitData` goes high, registered edge detect).
- Consecutive bytes may transfer on back-to-back cycles if `txReady` stays high: 5-cycle minimum frame.
- Byte count and tx index are 3 bits and never exceed 4; no wrap.

## Structure
- Shared package: `FRAME_BYTES`=5, rx state enum {RX_IDLE, RX_COLLECT, RX_HOLD}, tx state enum {TX_IDLE, TX_SEND}, error bit indices `ERR_RX_OVERRUN`=0, `ERR_TX_COLLISION`=1.
- One sub-module: `sandbox_tx_serializer` (edge detect, 40-bit shift, valid/ready), instantiated once. Rx assembly and timeout stay in the top.

## Test plan
- Rx frame 0x01,0xDE,0xAD,0xBE,0xEF, one byte every 10 cycles → `control`=0x01, `inputData`=0xDEADBEEF, `dataReceived`=1 the cycle after the last byte. Pulse `clearDR` → `dataReceived`=0 next cycle.
- `transmitData` rises with `status`=0x03, `outputData`=0x12345678, `txReady` always 1 → bytes 03,12,34,56,78 on 5 consecutive cycles. `transmitData` held high 100 cycles → no second frame.
- `txReady` toggling 1-of-3 cycles → same 5 bytes, `txByte` unchanged while stalled.
- `TIMEOUT_CYCLES`=16: send 2 bytes, then idle 16 cycles → `frameTimeout` pulse. Next 5 bytes form a correct frame.
- While in RX_HOLD, send byte 0x55 → `error[0]`=1, `inputData` unchanged. Second `transmitData` edge mid-frame → `error[1]`=1, frame completes intact.
- Assert `reset` after 3 rx bytes and 2 tx bytes → all outputs 0 next cycle. A fresh frame after reset is assembled correctly.
